// File: rtl/linia_op_if.sv
// Data bus for the linia_op delay line: input word in, delayed word and fill flag out.
interface linia_op_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] idata;
  logic [WIDTH-1:0] odata;
  logic             ovalid;

  modport master (output idata, input odata, input ovalid);
  modport slave  (input idata, output odata, output ovalid);
endinterface

// File: rtl/linia_op.sv
// Fixed-latency delay line: each word reappears DELAY clocks later, with a flag
// that goes high once every stage holds data sampled after reset.
module linia_op #(
  parameter int WIDTH = 5,
  parameter int DELAY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  linia_op_if.slave  bus
);

  if (DELAY == 0) begin : g_pass
    // Zero latency degenerates to wires; validity simply mirrors reset.
    assign bus.odata  = bus.idata;
    assign bus.ovalid = rst_n;
  end else begin : g_line
    localparam int CNT_W = ($clog2(DELAY + 1) < 1) ? 1 : $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DELAY);

    logic [CNT_W-1:0] fill_cnt;

    for (genvar i = 0; i < DELAY; i++) begin : g_stage
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;

      if (i == 0) begin : g_head
        assign d = bus.idata;
      end else begin : g_tail
        assign d = g_stage[i-1].q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end

    // Saturates at DELAY: from then on the last stage always holds fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fill_cnt <= '0;
      end else if (fill_cnt != FULL) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
    end

    assign bus.odata  = g_stage[DELAY-1].q;
    assign bus.ovalid = (fill_cnt == FULL);
  end

endmodule

// File: tb/tb_linia_op.sv
// Directed bench for linia_op: reset, pulse, square wave, counting, mid-stream
// reset, and the (1,1), (8,0), (16,7) parameter points sharing clock and reset.
module tb_linia_op;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  linia_op_if #(5)  b4 ();
  linia_op_if #(1)  b1 ();
  linia_op_if #(8)  b0 ();
  linia_op_if #(16) b7 ();

  linia_op #(5, 4)  u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  linia_op #(1, 1)  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  linia_op #(8, 0)  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  linia_op #(16, 7) u7 (.clk(clk), .rst_n(rst_n), .bus(b7));

  int checks = 0;
  int errors = 0;
  int ecount = 0;   // rising edges seen with rst_n high since the last reset

  // Words driven before each edge, indexed by the edge number that samples them.
  logic [4:0]  h4 [0:255];
  logic        h1 [0:255];
  logic [15:0] h7 [0:255];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive one word 5 ns into the cycle, check the pass-through copy, then clock
  // and compare every registered instance against its history.
  task automatic cyc(input logic [4:0] v);
    #4;
    b4.idata = v;
    b1.idata = v[0] ^ v[4];
    b0.idata = 8'(v * 7 + ecount);
    b7.idata = {v, 11'(ecount * 37 + 5)};
    h4[ecount + 1] = b4.idata;
    h1[ecount + 1] = b1.idata;
    h7[ecount + 1] = b7.idata;
    #1;
    check("d0_data",  32'(b0.odata),  32'(b0.idata));
    check("d0_valid", 32'(b0.ovalid), 32'(rst_n));
    @(posedge clk);
    if (rst_n) ecount++;
    #1;
    check("d4_data",  32'(b4.odata),  (ecount >= 4) ? 32'(h4[ecount - 3]) : 32'd0);
    check("d4_valid", 32'(b4.ovalid), 32'(ecount >= 4));
    check("d1_data",  32'(b1.odata),  (ecount >= 1) ? 32'(h1[ecount]) : 32'd0);
    check("d1_valid", 32'(b1.ovalid), 32'(ecount >= 1));
    check("d7_data",  32'(b7.odata),  (ecount >= 7) ? 32'(h7[ecount - 6]) : 32'd0);
    check("d7_valid", 32'(b7.ovalid), 32'(ecount >= 7));
  endtask

  initial begin
    b4.idata = '0;
    b1.idata = '0;
    b0.idata = '0;
    b7.idata = '0;

    // Reset held with clocks and random data running.
    for (int i = 0; i < 4; i++) cyc(5'($urandom));

    #2 rst_n = 1'b1;
    ecount = 0;

    // Single pulse sampled on edge 1.
    cyc(5'h1F);
    for (int i = 0; i < 6; i++) cyc(5'h00);

    // Square wave with mixed bit patterns in the low phase.
    for (int i = 0; i < 16; i++) cyc(((i % 4) < 2) ? 5'h1F : ((i % 8) == 2 ? 5'h0A : 5'h00));

    // Counting pattern.
    for (int k = 0; k < 32; k++) cyc(5'(k));

    // Asynchronous reset pulse in mid-stream, 7 ns wide, between edges.
    #4 rst_n = 1'b0;
    #1;
    check("async_d4_data",  32'(b4.odata),  32'd0);
    check("async_d4_valid", 32'(b4.ovalid), 32'd0);
    check("async_d7_data",  32'(b7.odata),  32'd0);
    check("async_d1_data",  32'(b1.odata),  32'd0);
    check("async_d0_valid", 32'(b0.ovalid), 32'd0);
    #6 rst_n = 1'b1;
    ecount = 0;

    for (int k = 0; k < 12; k++) cyc(5'(k + 17));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
